out_fm_st_addr_gen: RTL and testbench
=====================================

Name: out_fm_st_addr_gen

Overview:
Output-feature-map store engine. On store_start it walks an n1 x n0 output tile in row-major order, with column index c0 inner and row index c1 outer. For each element it reads the on-chip output buffer and issues one word write request to external memory over a valid/ready channel. It sits between the output buffer and the memory write port, and provides the address and data stream for storing each computed tile.

Parameters:
CW, 16, width of tile dimension inputs n0/n1
AW, 32, external memory word address width
DW, 32, data word width
BAW, 10, output buffer address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
store_start  input  1  single-cycle start pulse; sampled only in IDLE
base_addr  input  AW  external word address of tile element (0,0); latched at start
row_stride  input  AW  external word distance between consecutive rows; latched at start
n0  input  CW  words per row; latched at start
n1  input  CW  rows per tile; latched at start
buf_rd_ena  output  1  output buffer read strobe
buf_rd_addr  output  BAW  output buffer read address
buf_rd_data  input  DW  buffer read data, valid exactly 1 cycle after buf_rd_ena
wr_valid  output  1  write request valid
wr_addr  output  AW  write word address
wr_data  output  DW  write data
wr_ready  input  1  memory accepts request when wr_valid && wr_ready
busy  output  1  high from the cycle after an accepted start until the cycle done pulses
done  output  1  one-cycle pulse when the last write has been accepted

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset values: all outputs 0. State IDLE. Skid FIFO empty. In-flight flag 0. Internal counters 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - store_start=1 with n0!=0 and n1!=0: latch inputs, c0=c1=0, go to RUN.
  - store_start=1 with n0==0 or n1==0: done=1 next cycle, remain IDLE, no reads or writes.
- Addressing (no multipliers; use running row-base accumulators):
  - buf_rd_addr = (c1*n0 + c0) mod 2^BAW.
  - External address = (base_addr + c1*row_stride + c0) mod 2^AW.
  - Address wrap-around is silent.
- Read pipeline:
  - A buffer read issued in cycle t is pushed into a 2-entry skid FIFO carrying {addr, data} at the end of cycle t+1.
  - In-flight flag = read issued last cycle.
  - Issue condition in RUN: (fifo_count + inflight < 2) OR (wr_valid && wr_ready).
  - Guarantees no data loss under backpressure and 1 word/cycle throughput when wr_ready stays high.
  - fifo_count never exceeds 2.
- Index advance on each issued read: c0 increments. At c0==n0-1, c0 wraps to 0 and c1 increments. Issuing index (n0-1, n1-1) moves the state to DRAIN.
- Write channel:
  - wr_valid = FIFO non-empty. wr_addr/wr_data = FIFO head.
  - Head stays stable while wr_valid && !wr_ready.
  - Pop on handshake. Push and pop in the same cycle are allowed.
- Latency: store_start in cycle 0 → buf_rd_ena in cycle 1 → wr_valid in cycle 3.
- DRAIN: when the FIFO is empty and inflight==0, done=1 for one cycle, busy=0, go to IDLE. Done asserts the cycle after the final handshake.
- store_start while busy: ignored, no side effects.
- rst mid-operation: abort immediately. Discard queued data. No done pulse. The next start begins at index (0,0).
- busy=1 in RUN and DRAIN only.

Test Plan:
1. n0=4, n1=3, base_addr=0x1000, row_stride=16, wr_ready=1, start at cycle 0 → buf_rd_addr 0..11 in cycles 1..12; wr_addr 0x1000-0x1003, 0x1010-0x1013, 0x1020-0x1023 back-to-back in cycles 3..14; done=1 only in cycle 15; busy high cycles 1..14.
2. Same as 1 with wr_ready pseudo-randomly 50% low → identical 12-entry {addr,data} sequence, no drop or duplicate; payload stable during every stall; fifo_count+inflight ≤2 at all times; done one cycle after the 12th handshake.
3. n0=0, n1=5, start → done in cycle 1; buf_rd_ena, wr_valid and busy stay 0.
4. store_start pulsed again in cycle 6 of test 1 → ignored, output unchanged. Second start after done with base_addr=0x2000, n0=2, n1=1 → writes at 0x2000 and 0x2001, buf_rd_addr 0 and 1.
5. rst asserted for 1 cycle after 5 handshakes of test 1 → next cycle wr_valid=0, busy=0, buf_rd_ena=0, done never pulses. A new start then begins at buf_rd_addr 0.
6. base_addr=0xFFFFFFFE, n0=4, n1=1 → wr_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001, then done.

Source files
------------

// File: rtl/out_fm_st_addr_gen_if.sv
// Signal bundle between the output-feature-map store engine, its output buffer and the
// memory write port.
interface out_fm_st_addr_gen_if #(
  parameter int CW  = 16,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BAW = 10
);
  logic           store_start;
  logic [AW-1:0]  base_addr;
  logic [AW-1:0]  row_stride;
  logic [CW-1:0]  n0;
  logic [CW-1:0]  n1;
  logic           buf_rd_ena;
  logic [BAW-1:0] buf_rd_addr;
  logic [DW-1:0]  buf_rd_data;
  logic           wr_valid;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_ready;
  logic           busy;
  logic           done;

  modport master (
    input  store_start, base_addr, row_stride, n0, n1, buf_rd_data, wr_ready,
    output buf_rd_ena, buf_rd_addr, wr_valid, wr_addr, wr_data, busy, done
  );

  modport slave (
    output store_start, base_addr, row_stride, n0, n1, buf_rd_data, wr_ready,
    input  buf_rd_ena, buf_rd_addr, wr_valid, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/out_fm_st_addr_gen.sv
// Output tile store engine: walks an n1 x n0 tile row-major, reads the output buffer and
// streams {address, data} write requests through a 2-entry skid FIFO.
module out_fm_st_addr_gen #(
  parameter int CW  = 16,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BAW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  out_fm_st_addr_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic           done_q, done_set;

  logic [CW-1:0]  n0_q, n1_q, c0, c1;
  logic [AW-1:0]  stride_q, row_base;
  logic [BAW-1:0] rd_idx;

  logic           vld_p0;
  logic [AW-1:0]  addr_p0;

  logic [1:0]     cnt, cnt_nxt;
  logic [AW-1:0]  addr_f0, addr_f1;
  logic [DW-1:0]  data_f0, data_f1;

  logic           start_ok, start_zero, issue, push, pop, row_end, last_idx;

  assign start_ok   = (state == IDLE) && bus.store_start && (bus.n0 != '0) && (bus.n1 != '0);
  assign start_zero = (state == IDLE) && bus.store_start && ((bus.n0 == '0) || (bus.n1 == '0));
  assign push       = vld_p0;
  assign pop        = (cnt != 2'd0) && bus.wr_ready;
  assign cnt_nxt    = cnt + {1'b0, push} - {1'b0, pop};
  // A slot is free if fewer than two words are queued or in flight, or one leaves this cycle.
  assign issue      = (state == RUN) &&
                      ((({1'b0, cnt} + {2'b0, vld_p0}) < 3'd2) || pop);
  assign row_end    = (c0 == n0_q - 1'b1);
  assign last_idx   = row_end && (c1 == n1_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_set;
    end
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok)        state_nxt = RUN;
        else if (start_zero) done_set  = 1'b1;
      end
      RUN: begin
        if (issue && last_idx) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!vld_p0 && (cnt_nxt == 2'd0)) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.buf_rd_ena  = issue;
    bus.buf_rd_addr = rd_idx;
    bus.busy        = (state != IDLE);
    bus.done        = done_q;
    bus.wr_valid    = (cnt != 2'd0);
    bus.wr_addr     = (cnt != 2'd0) ? addr_f0 : '0;
    bus.wr_data     = (cnt != 2'd0) ? data_f0 : '0;
  end

  // Stage p0: index walk and read issue; external address follows a running row base.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0     <= '0;
      c1     <= '0;
      rd_idx <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= issue;
      if (start_ok) begin
        c0     <= '0;
        c1     <= '0;
        rd_idx <= '0;
      end else if (issue) begin
        rd_idx <= rd_idx + 1'b1;
        if (row_end) begin
          c0 <= '0;
          c1 <= c1 + 1'b1;
        end else begin
          c0 <= c0 + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      n0_q     <= bus.n0;
      n1_q     <= bus.n1;
      stride_q <= bus.row_stride;
      row_base <= bus.base_addr;
    end else if (issue && row_end) begin
      row_base <= row_base + stride_q;
    end
    if (issue) addr_p0 <= row_base + {{(AW-CW){1'b0}}, c0};
  end

  // Stage p1: buffer data joins its address in the skid FIFO; slot 0 is the head.
  always_ff @(posedge clk) begin
    if (rst) cnt <= 2'd0;
    else     cnt <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (pop && (cnt == 2'd2)) begin
        addr_f0 <= addr_f1;
        data_f0 <= data_f1;
        addr_f1 <= addr_p0;
        data_f1 <= bus.buf_rd_data;
      end else if (pop || (cnt == 2'd0)) begin
        addr_f0 <= addr_p0;
        data_f0 <= bus.buf_rd_data;
      end else begin
        addr_f1 <= addr_p0;
        data_f1 <= bus.buf_rd_data;
      end
    end else if (pop) begin
      addr_f0 <= addr_f1;
      data_f0 <= data_f1;
    end
  end

endmodule

// File: tb/tb_out_fm_st_addr_gen.sv
// Bench for out_fm_st_addr_gen: directed table, hand sequences and random tiles against
// a loop-based reference of the tile walk.
module tb_out_fm_st_addr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  out_fm_st_addr_gen_if bus ();

  out_fm_st_addr_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] salt = 16'h0;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {salt, 6'd0, a};
  endfunction

  always @(posedge clk) if (bus.buf_rd_ena) bus.buf_rd_data <= pat(bus.buf_rd_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor state
  logic        mon_en = 1'b0;
  int          start_cyc, rel;
  int          reads, hs, valid_cnt, busy_cnt, done_cnt;
  int          first_rd_rel, first_wr_rel, last_hs_rel, busy_first, busy_last, done_rel;
  logic [9:0]  rd_q[$];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic        prev_stall;
  logic [31:0] prev_addr, prev_data;

  task automatic reset_mon();
    reads = 0; hs = 0; valid_cnt = 0; busy_cnt = 0; done_cnt = 0;
    first_rd_rel = -1; first_wr_rel = -1; last_hs_rel = -1;
    busy_first = -1; busy_last = -1; done_rel = -1;
    rd_q.delete(); wq_a.delete(); wq_d.delete();
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - start_cyc;
      chk("outstanding_le_2", 64'((reads - hs) <= 2), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.wr_valid), 64'd1);
        chk("stall_addr", 64'(bus.wr_addr), 64'(prev_addr));
        chk("stall_data", 64'(bus.wr_data), 64'(prev_data));
      end
      if (bus.buf_rd_ena) begin
        if (reads == 0) first_rd_rel = rel;
        reads++;
        rd_q.push_back(bus.buf_rd_addr);
      end
      if (bus.wr_valid) begin
        if (first_wr_rel < 0) first_wr_rel = rel;
        valid_cnt++;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        hs++;
        wq_a.push_back(bus.wr_addr);
        wq_d.push_back(bus.wr_data);
        last_hs_rel = rel;
      end
      prev_stall = bus.wr_valid && !bus.wr_ready;
      prev_addr  = bus.wr_addr;
      prev_data  = bus.wr_data;
      if (bus.busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_rel = rel;
        chk("busy_low_at_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  // rmode 0: wr_ready always high; 1: random 50%. restart_at: cycle of a stray start pulse.
  task automatic run_tile(input logic [31:0] base, input logic [31:0] stride,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input int rmode, input int restart_at);
    int g, n, i;
    logic [31:0] ea;
    reset_mon();
    @(posedge clk); #1;
    salt            = 16'($urandom);
    bus.base_addr   = base;
    bus.row_stride  = stride;
    bus.n0          = a0;
    bus.n1          = a1;
    bus.store_start = 1'b1;
    bus.wr_ready    = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    start_cyc       = cyc;
    mon_en          = 1'b1;
    g = 0;
    while (done_cnt == 0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
      bus.store_start = (restart_at >= 0) && ((cyc - start_cyc) == restart_at);
      if (bus.store_start) begin
        bus.base_addr = 32'hDEAD0000;
        bus.n0        = 16'd1;
        bus.n1        = 16'd1;
      end
      bus.wr_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    bus.wr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 mon_en = 1'b0;

    chk("timeout", 64'(g < 3000), 64'd1);
    n = int'(a0) * int'(a1);
    chk("rd_count", 64'(reads), 64'(n));
    chk("wr_count", 64'(hs), 64'(n));
    i = 0;
    for (int r = 0; r < int'(a1); r++) begin
      for (int c = 0; c < int'(a0); c++) begin
        if (i < hs) begin
          ea = base + 32'(r) * stride + 32'(c);
          chk("wr_addr", 64'(wq_a[i]), 64'(ea));
          chk("wr_data", 64'(wq_d[i]), 64'(pat(10'(i))));
        end
        if (i < reads) chk("buf_rd_addr", 64'(rd_q[i]), 64'(10'(i)));
        i++;
      end
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    if (n > 0) begin
      chk("done_after_last_hs", 64'(done_rel), 64'(last_hs_rel + 1));
      chk("busy_first", 64'(busy_first), 64'd1);
      chk("busy_last", 64'(busy_last), 64'(done_rel - 1));
      chk("first_rd_cycle", 64'(first_rd_rel), 64'd1);
      if (rmode == 0) chk("first_wr_cycle", 64'(first_wr_rel), 64'd3);
    end else begin
      chk("zero_done_cycle", 64'(done_rel), 64'd1);
      chk("zero_busy", 64'(busy_cnt), 64'd0);
      chk("zero_valid", 64'(valid_cnt), 64'd0);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] n0;
    logic [15:0] n1;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_cnt;
    int          exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int g;
    tbl[0] = '{32'h0000_1000, 32'd16,        16'd4, 16'd3, 32'h0000_1000, 32'h0000_1023, 12, 15};
    tbl[1] = '{32'h0000_0000, 32'd4,         16'd0, 16'd5, 32'h0,         32'h0,          0,  1};
    tbl[2] = '{32'hFFFF_FFFE, 32'd8,         16'd4, 16'd1, 32'hFFFF_FFFE, 32'h0000_0001,  4,  7};
    tbl[3] = '{32'h0000_2000, 32'd64,        16'd2, 16'd1, 32'h0000_2000, 32'h0000_2001,  2,  5};
    tbl[4] = '{32'h0000_0040, 32'h100,       16'd3, 16'd2, 32'h0000_0040, 32'h0000_0142,  6,  9};
    tbl[5] = '{32'h0000_0005, 32'd3,         16'd1, 16'd1, 32'h0000_0005, 32'h0000_0005,  1,  4};
    tbl[6] = '{32'h0000_0010, 32'hFFFF_FFF0, 16'd2, 16'd3, 32'h0000_0010, 32'hFFFF_FFF1,  6,  9};

    bus.store_start = 1'b0;
    bus.base_addr   = '0;
    bus.row_stride  = '0;
    bus.n0          = '0;
    bus.n1          = '0;
    bus.wr_ready    = 1'b0;
    reset_mon();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_buf_rd_ena", 64'(bus.buf_rd_ena), 64'd0);
    chk("rst_buf_rd_addr", 64'(bus.buf_rd_addr), 64'd0);
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[k]) begin
      run_tile(tbl[k].base, tbl[k].stride, tbl[k].n0, tbl[k].n1, 0, -1);
      chk("tbl_count", 64'(hs), 64'(tbl[k].exp_cnt));
      chk("tbl_done_cycle", 64'(done_rel), 64'(tbl[k].exp_done));
      if (tbl[k].exp_cnt > 0 && hs > 0) begin
        chk("tbl_first_addr", 64'(wq_a[0]), 64'(tbl[k].exp_first));
        chk("tbl_last_addr", 64'(wq_a[hs-1]), 64'(tbl[k].exp_last));
      end
    end

    // Backpressure on the reference tile
    run_tile(32'h0000_1000, 32'd16, 16'd4, 16'd3, 1, -1);

    // Stray start while busy, then a fresh small tile
    run_tile(32'h0000_1000, 32'd16, 16'd4, 16'd3, 0, 6);
    run_tile(32'h0000_2000, 32'd16, 16'd2, 16'd1, 0, -1);

    // Abort with rst after five handshakes
    reset_mon();
    @(posedge clk); #1;
    bus.base_addr = 32'h0000_1000; bus.row_stride = 32'd16;
    bus.n0 = 16'd4; bus.n1 = 16'd3; bus.wr_ready = 1'b1;
    bus.store_start = 1'b1; start_cyc = cyc; mon_en = 1'b1;
    @(posedge clk); #1 bus.store_start = 1'b0;
    g = 0;
    while (hs < 5 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("abort_reach_5", 64'(g < 100), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_buf_rd_ena", 64'(bus.buf_rd_ena), 64'd0);
    repeat (20) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    run_tile(32'h0000_3000, 32'd8, 16'd3, 16'd2, 0, -1);

    // Random tiles under random backpressure
    for (int k = 0; k < 8; k++) begin
      run_tile($urandom, 32'($urandom_range(0, 2000)),
               16'($urandom_range(0, 6)), 16'($urandom_range(0, 5)), 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
